// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline stage registers: occupancy codes, FSM states,
// reset PC and the flattened payload layouts of each stage boundary.
package pipe_pkg;

  localparam logic [1:0] OCC_EMPTY = 2'd0;
  localparam logic [1:0] OCC_ONE   = 2'd1;
  localparam logic [1:0] OCC_TWO   = 2'd2;

  localparam logic [31:0] RESET_PC = 32'h8000_0000;

  typedef enum logic [1:0] {
    EMPTY,
    FULL,
    FULL_SKID
  } state_e;

  localparam int XLEN   = 32;
  localparam int RD_W   = 5;
  localparam int CTRL_W = 8;

  // Field offsets are LSB positions inside each stage's flattened payload.
  localparam int IFID_PC_LSB    = 0;
  localparam int IFID_INSTR_LSB = IFID_PC_LSB + XLEN;
  localparam int IFID_W         = IFID_INSTR_LSB + XLEN;

  localparam int IDEX_PC_LSB   = 0;
  localparam int IDEX_RS1_LSB  = IDEX_PC_LSB + XLEN;
  localparam int IDEX_RS2_LSB  = IDEX_RS1_LSB + XLEN;
  localparam int IDEX_IMM_LSB  = IDEX_RS2_LSB + XLEN;
  localparam int IDEX_RD_LSB   = IDEX_IMM_LSB + XLEN;
  localparam int IDEX_CTRL_LSB = IDEX_RD_LSB + RD_W;
  localparam int IDEX_W        = IDEX_CTRL_LSB + CTRL_W;

  localparam int EXMEM_PC_LSB    = 0;
  localparam int EXMEM_ALU_LSB   = EXMEM_PC_LSB + XLEN;
  localparam int EXMEM_STORE_LSB = EXMEM_ALU_LSB + XLEN;
  localparam int EXMEM_RD_LSB    = EXMEM_STORE_LSB + XLEN;
  localparam int EXMEM_CTRL_LSB  = EXMEM_RD_LSB + RD_W;
  localparam int EXMEM_W         = EXMEM_CTRL_LSB + CTRL_W;

  localparam int MEMWB_RESULT_LSB = 0;
  localparam int MEMWB_RD_LSB     = MEMWB_RESULT_LSB + XLEN;
  localparam int MEMWB_CTRL_LSB   = MEMWB_RD_LSB + RD_W;
  localparam int MEMWB_W          = MEMWB_CTRL_LSB + CTRL_W;

  function automatic logic [1:0] occ_count(input logic main_valid, input logic skid_valid);
    if (main_valid && skid_valid) return OCC_TWO;
    if (main_valid || skid_valid) return OCC_ONE;
    return OCC_EMPTY;
  endfunction

endpackage

// File: rtl/pipe_stage_reg_if.sv
// One valid/ready/data stream. The stage register takes the upstream side as
// slave and drives the downstream side as master.
interface pipe_stage_reg_if #(
  parameter int DATA_W = 32
) ();
  logic              valid;
  logic              ready;
  logic [DATA_W-1:0] data;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/pipe_slot.sv
// One payload register with load enable and a valid bit; clear wins over load
// and leaves the data untouched.
module pipe_slot #(
  parameter int                DATA_W    = 32,
  parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              clear,
  input  logic [DATA_W-1:0] d,
  output logic [DATA_W-1:0] q,
  output logic              valid
);

  // NOTE: sequential state is written with <= so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      q     <= RESET_VAL;
    end else begin
      if (clear)     valid <= 1'b0;
      else if (load) valid <= 1'b1;
      // NOTE: a clear only drops the valid bit; stale data is don't-care and is not scrubbed.
      if (load && !clear) q <= d;
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// Generic valid/ready pipeline register: two-entry skid buffer, single register,
// or pure wires, with synchronous flush and an occupancy count.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int                DATA_W    = 32,
  parameter logic [DATA_W-1:0] RESET_VAL = '0,
  parameter bit                SKID      = 1'b1,
  parameter bit                BYPASS    = 1'b0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  pipe_stage_reg_if.slave     s,
  pipe_stage_reg_if.master    m,
  output logic [1:0]          occupancy
);

  if (BYPASS) begin : g_bypass
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ rst;

    assign m.valid    = s.valid & ~flush;
    assign s.ready    = m.ready;
    assign m.data     = s.data;
    assign occupancy  = OCC_EMPTY;

  end else if (SKID) begin : g_skid
    state_e            state, state_next;
    logic              s_ready_q;
    logic              in_xfer, out_xfer;
    logic              main_load, main_clear, skid_load, skid_clear;
    logic [DATA_W-1:0] main_d, main_q, skid_q;
    logic              main_valid, skid_valid;

    assign in_xfer  = s.valid & s_ready_q;
    assign out_xfer = m.valid & m.ready;

    // NOTE: every signal written here gets a default first so no latch is inferred.
    always_comb begin
      state_next = state;
      main_load  = 1'b0;
      main_clear = 1'b0;
      skid_load  = 1'b0;
      skid_clear = 1'b0;
      main_d     = s.data;
      if (flush) begin
        state_next = EMPTY;
        main_clear = 1'b1;
        skid_clear = 1'b1;
      end else begin
        case (state)
          EMPTY: begin
            if (in_xfer) begin
              state_next = FULL;
              main_load  = 1'b1;
            end
          end
          FULL: begin
            if (in_xfer && out_xfer) begin
              main_load = 1'b1;
            end else if (out_xfer) begin
              state_next = EMPTY;
              main_clear = 1'b1;
            end else if (in_xfer) begin
              state_next = FULL_SKID;
              skid_load  = 1'b1;
            end
          end
          FULL_SKID: begin
            if (out_xfer) begin
              state_next = FULL;
              main_load  = 1'b1;
              main_d     = skid_q;
              skid_clear = 1'b1;
            end
          end
          default: state_next = EMPTY;
        endcase
      end
    end

    // s_ready is precomputed from the next state so it never depends on s_valid.
    always_ff @(posedge clk) begin
      if (rst) begin
        state     <= EMPTY;
        s_ready_q <= 1'b0;
      end else begin
        state     <= state_next;
        s_ready_q <= (state_next != FULL_SKID);
      end
    end

    pipe_slot #(.DATA_W(DATA_W), .RESET_VAL(RESET_VAL)) u_main (
      .clk(clk), .rst(rst), .load(main_load), .clear(main_clear),
      .d(main_d), .q(main_q), .valid(main_valid)
    );

    pipe_slot #(.DATA_W(DATA_W), .RESET_VAL(RESET_VAL)) u_skid (
      .clk(clk), .rst(rst), .load(skid_load), .clear(skid_clear),
      .d(s.data), .q(skid_q), .valid(skid_valid)
    );

    assign s.ready   = s_ready_q;
    assign m.valid   = (state != EMPTY);
    assign m.data    = main_q;
    assign occupancy = occ_count(main_valid, skid_valid);

  end else begin : g_single
    logic              in_xfer, out_xfer, ready_c;
    logic [DATA_W-1:0] main_q;
    logic              main_valid;

    assign ready_c  = ~rst & (~main_valid | m.ready);
    assign in_xfer  = s.valid & ready_c;
    assign out_xfer = main_valid & m.ready;

    pipe_slot #(.DATA_W(DATA_W), .RESET_VAL(RESET_VAL)) u_main (
      .clk(clk), .rst(rst),
      .load(in_xfer & ~flush),
      .clear(flush | (out_xfer & ~in_xfer)),
      .d(s.data), .q(main_q), .valid(main_valid)
    );

    assign s.ready   = ready_c;
    assign m.valid   = main_valid;
    assign m.data    = main_q;
    assign occupancy = occ_count(main_valid, 1'b0);
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: skid, single-register and bypass builds
// side by side, each scenario in its own task with hand-computed expectations.
module tb_pipe_stage_reg;
  import pipe_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       flush1, flush0, flushb;
  logic [1:0] occ1, occ0, occb;
  int         errors = 0;
  int         checks = 0;

  always #5 clk = ~clk;

  pipe_stage_reg_if #(.DATA_W(32)) up1 (), dn1 (), up0 (), dn0 (), upb (), dnb ();

  pipe_stage_reg #(.DATA_W(32), .RESET_VAL(RESET_PC), .SKID(1'b1), .BYPASS(1'b0)) u_skid (
    .clk(clk), .rst(rst), .flush(flush1), .s(up1.slave), .m(dn1.master), .occupancy(occ1)
  );

  pipe_stage_reg #(.DATA_W(32), .RESET_VAL(32'h0), .SKID(1'b0), .BYPASS(1'b0)) u_single (
    .clk(clk), .rst(rst), .flush(flush0), .s(up0.slave), .m(dn0.master), .occupancy(occ0)
  );

  pipe_stage_reg #(.DATA_W(32), .RESET_VAL(32'h0), .SKID(1'b1), .BYPASS(1'b1)) u_bypass (
    .clk(clk), .rst(rst), .flush(flushb), .s(upb.slave), .m(dnb.master), .occupancy(occb)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    flush1 = 1'b0; flush0 = 1'b0; flushb = 1'b0;
    up1.valid = 1'b0; up1.data = '0; dn1.ready = 1'b0;
    up0.valid = 1'b0; up0.data = '0; dn0.ready = 1'b1;
    upb.valid = 1'b0; upb.data = '0; dnb.ready = 1'b0;
    step();
    step();
    checks++; if (dn1.valid !== 1'b0) begin errors++; $display("FAIL reset_m_valid: got %b want 0", dn1.valid); end
    checks++; if (up1.ready !== 1'b0) begin errors++; $display("FAIL reset_s_ready: got %b want 0", up1.ready); end
    checks++; if (occ1 !== OCC_EMPTY) begin errors++; $display("FAIL reset_occ: got %0d want 0", occ1); end
    checks++; if (dn1.data !== 32'h8000_0000) begin errors++; $display("FAIL reset_m_data: got %h want 80000000", dn1.data); end
    checks++; if (up0.ready !== 1'b0) begin errors++; $display("FAIL reset_single_s_ready: got %b want 0", up0.ready); end
    checks++; if (dn0.valid !== 1'b0) begin errors++; $display("FAIL reset_single_m_valid: got %b want 0", dn0.valid); end
    rst = 1'b0;
    #1;
    checks++; if (up1.ready !== 1'b0) begin errors++; $display("FAIL reset_release_s_ready_reg: got %b want 0", up1.ready); end
    checks++; if (up0.ready !== 1'b1) begin errors++; $display("FAIL reset_release_single_s_ready: got %b want 1", up0.ready); end
    step();
    checks++; if (up1.ready !== 1'b1) begin errors++; $display("FAIL reset_first_cycle_s_ready: got %b want 1", up1.ready); end
  endtask

  task automatic test_stream();
    dn1.ready = 1'b1;
    up1.valid = 1'b1;
    checks++; if (dn1.valid !== 1'b0) begin errors++; $display("FAIL stream_pre_valid: got %b want 0", dn1.valid); end
    for (int i = 1; i <= 8; i++) begin
      up1.data = 32'(i);
      #1;
      checks++; if (up1.ready !== 1'b1) begin errors++; $display("FAIL stream_s_ready beat %0d: got %b want 1", i, up1.ready); end
      step();
      checks++; if (dn1.valid !== 1'b1 || dn1.data !== 32'(i)) begin
        errors++; $display("FAIL stream_out beat %0d: got valid=%b data=%h want valid=1 data=%h", i, dn1.valid, dn1.data, 32'(i));
      end
      checks++; if (occ1 !== OCC_ONE) begin errors++; $display("FAIL stream_occ beat %0d: got %0d want 1", i, occ1); end
    end
    up1.valid = 1'b0;
    step();
    checks++; if (dn1.valid !== 1'b0 || occ1 !== OCC_EMPTY) begin
      errors++; $display("FAIL stream_drain: got valid=%b occ=%0d want valid=0 occ=0", dn1.valid, occ1);
    end
  endtask

  task automatic test_backpressure();
    dn1.ready = 1'b0;
    up1.valid = 1'b1;
    up1.data  = 32'hA;
    #1;
    checks++; if (up1.ready !== 1'b1) begin errors++; $display("FAIL bp_accept_a: got %b want 1", up1.ready); end
    step();
    checks++; if (occ1 !== OCC_ONE || dn1.data !== 32'hA) begin errors++; $display("FAIL bp_after_a: got occ=%0d data=%h want occ=1 data=a", occ1, dn1.data); end
    up1.data = 32'hB;
    #1;
    checks++; if (up1.ready !== 1'b1) begin errors++; $display("FAIL bp_accept_b: got %b want 1", up1.ready); end
    step();
    checks++; if (occ1 !== OCC_TWO || up1.ready !== 1'b0) begin errors++; $display("FAIL bp_full: got occ=%0d s_ready=%b want occ=2 s_ready=0", occ1, up1.ready); end
    up1.data = 32'hC;
    step();
    checks++; if (occ1 !== OCC_TWO || up1.ready !== 1'b0 || dn1.data !== 32'hA) begin
      errors++; $display("FAIL bp_hold_c: got occ=%0d s_ready=%b data=%h want occ=2 s_ready=0 data=a", occ1, up1.ready, dn1.data);
    end
    dn1.ready = 1'b1;
    step();
    checks++; if (dn1.valid !== 1'b1 || dn1.data !== 32'hB || occ1 !== OCC_ONE || up1.ready !== 1'b1) begin
      errors++; $display("FAIL bp_out_b: got valid=%b data=%h occ=%0d s_ready=%b want 1 b 1 1", dn1.valid, dn1.data, occ1, up1.ready);
    end
    step();
    checks++; if (dn1.valid !== 1'b1 || dn1.data !== 32'hC) begin errors++; $display("FAIL bp_out_c: got valid=%b data=%h want valid=1 data=c", dn1.valid, dn1.data); end
    up1.valid = 1'b0;
    step();
    checks++; if (dn1.valid !== 1'b0) begin errors++; $display("FAIL bp_drain: got %b want 0", dn1.valid); end
  endtask

  task automatic test_hold();
    dn1.ready = 1'b0;
    up1.valid = 1'b1;
    up1.data  = 32'hDEAD_BEEF;
    step();
    for (int k = 0; k < 5; k++) begin
      up1.data = (k % 2 == 0) ? 32'h1111_1111 : 32'h2222_2222;
      step();
      checks++; if (dn1.valid !== 1'b1 || dn1.data !== 32'hDEAD_BEEF) begin
        errors++; $display("FAIL hold_cycle %0d: got valid=%b data=%h want valid=1 data=deadbeef", k, dn1.valid, dn1.data);
      end
    end
    checks++; if (occ1 !== OCC_TWO) begin errors++; $display("FAIL hold_occ: got %0d want 2", occ1); end
    up1.valid = 1'b0;
    dn1.ready = 1'b1;
    step();
    checks++; if (dn1.valid !== 1'b1 || dn1.data !== 32'h1111_1111) begin
      errors++; $display("FAIL hold_skid_out: got valid=%b data=%h want valid=1 data=11111111", dn1.valid, dn1.data);
    end
    step();
    checks++; if (dn1.valid !== 1'b0) begin errors++; $display("FAIL hold_drain: got %b want 0", dn1.valid); end
  endtask

  task automatic test_flush();
    dn1.ready = 1'b0;
    up1.valid = 1'b1;
    up1.data  = 32'h55;
    step();
    up1.data = 32'h66;
    step();
    checks++; if (occ1 !== OCC_TWO) begin errors++; $display("FAIL flush_setup_occ: got %0d want 2", occ1); end
    flush1   = 1'b1;
    up1.data = 32'h77;
    step();
    flush1    = 1'b0;
    up1.valid = 1'b0;
    dn1.ready = 1'b1;
    #1;
    checks++; if (dn1.valid !== 1'b0 || occ1 !== OCC_EMPTY || up1.ready !== 1'b1) begin
      errors++; $display("FAIL flush_skid_next: got valid=%b occ=%0d s_ready=%b want 0 0 1", dn1.valid, occ1, up1.ready);
    end
    for (int k = 0; k < 4; k++) begin
      step();
      checks++; if (dn1.valid !== 1'b0) begin errors++; $display("FAIL flush_no_emerge %0d: got %b want 0", k, dn1.valid); end
    end
    up1.valid = 1'b1;
    up1.data  = 32'h88;
    step();
    flush1   = 1'b1;
    up1.data = 32'h99;
    step();
    flush1    = 1'b0;
    up1.valid = 1'b0;
    #1;
    checks++; if (dn1.valid !== 1'b0 || occ1 !== OCC_EMPTY) begin
      errors++; $display("FAIL flush_full_accept: got valid=%b occ=%0d want 0 0", dn1.valid, occ1);
    end
    step();
    checks++; if (dn1.valid !== 1'b0) begin errors++; $display("FAIL flush_full_no_emerge: got %b want 0", dn1.valid); end
  endtask

  task automatic test_single();
    dn0.ready = 1'b1;
    up0.valid = 1'b1;
    up0.data  = 32'h1;
    #1;
    checks++; if (up0.ready !== 1'b1) begin errors++; $display("FAIL single_empty_ready: got %b want 1", up0.ready); end
    step();
    checks++; if (dn0.valid !== 1'b1 || dn0.data !== 32'h1 || occ0 !== OCC_ONE) begin
      errors++; $display("FAIL single_beat1: got valid=%b data=%h occ=%0d want 1 1 1", dn0.valid, dn0.data, occ0);
    end
    up0.data = 32'h2;
    #1;
    checks++; if (up0.ready !== 1'b1) begin errors++; $display("FAIL single_ready_hi: got %b want 1", up0.ready); end
    step();
    checks++; if (dn0.data !== 32'h2) begin errors++; $display("FAIL single_beat2: got %h want 2", dn0.data); end
    dn0.ready = 1'b0;
    up0.data  = 32'h3;
    #1;
    checks++; if (up0.ready !== 1'b0) begin errors++; $display("FAIL single_ready_lo: got %b want 0", up0.ready); end
    step();
    checks++; if (dn0.data !== 32'h2 || dn0.valid !== 1'b1) begin errors++; $display("FAIL single_stall_hold: got valid=%b data=%h want 1 2", dn0.valid, dn0.data); end
    dn0.ready = 1'b1;
    #1;
    checks++; if (up0.ready !== 1'b1) begin errors++; $display("FAIL single_ready_back: got %b want 1", up0.ready); end
    step();
    checks++; if (dn0.data !== 32'h3) begin errors++; $display("FAIL single_beat3: got %h want 3", dn0.data); end
    up0.valid = 1'b0;
    step();
    checks++; if (dn0.valid !== 1'b0 || occ0 !== OCC_EMPTY) begin errors++; $display("FAIL single_drain: got valid=%b occ=%0d want 0 0", dn0.valid, occ0); end
  endtask

  task automatic test_bypass();
    upb.valid = 1'b1;
    upb.data  = 32'h1234_5678;
    dnb.ready = 1'b1;
    #1;
    checks++; if (dnb.valid !== 1'b1 || dnb.data !== 32'h1234_5678 || upb.ready !== 1'b1 || occb !== OCC_EMPTY) begin
      errors++; $display("FAIL bypass_pass: got valid=%b data=%h ready=%b occ=%0d want 1 12345678 1 0", dnb.valid, dnb.data, upb.ready, occb);
    end
    flushb    = 1'b1;
    dnb.ready = 1'b0;
    #1;
    checks++; if (dnb.valid !== 1'b0 || upb.ready !== 1'b0) begin
      errors++; $display("FAIL bypass_flush_ready: got valid=%b ready=%b want 0 0", dnb.valid, upb.ready);
    end
    flushb    = 1'b0;
    upb.valid = 1'b0;
  endtask

  task automatic test_reset_mid();
    dn1.ready = 1'b0;
    up1.valid = 1'b1;
    up1.data  = 32'hAAAA;
    step();
    up1.data = 32'hBBBB;
    step();
    checks++; if (occ1 !== OCC_TWO) begin errors++; $display("FAIL rmid_setup_occ: got %0d want 2", occ1); end
    up1.valid = 1'b0;
    rst = 1'b1;
    step();
    checks++; if (dn1.valid !== 1'b0 || dn1.data !== RESET_PC || up1.ready !== 1'b0 || occ1 !== OCC_EMPTY) begin
      errors++; $display("FAIL rmid_reset: got valid=%b data=%h s_ready=%b occ=%0d want 0 80000000 0 0", dn1.valid, dn1.data, up1.ready, occ1);
    end
    step();
    rst = 1'b0;
    #1;
    checks++; if (up1.ready !== 1'b0) begin errors++; $display("FAIL rmid_ready_low: got %b want 0", up1.ready); end
    step();
    checks++; if (up1.ready !== 1'b1 || dn1.valid !== 1'b0) begin
      errors++; $display("FAIL rmid_release: got s_ready=%b valid=%b want 1 0", up1.ready, dn1.valid);
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_hold();
    test_flush();
    test_single();
    test_bypass();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
- Generic valid/ready pipeline register that replaces the per-stage hand-written bus registers (IF/ID, ID/EX, EX/MEM, MEM/WB).
- The payload is one flattened vector of width DATA_W. Each stage packs its control and data fields into it.
- Adds full throughput, optional skid buffering, synchronous flush and an occupancy output.
- A BYPASS mode keeps single-cycle builds working: the block becomes pure wires.

Parameters:
- DATA_W, 32: payload width in bits, 1..1024.
- RESET_VAL, {DATA_W{1'b0}}: value of m_data after reset. The ID/EX instance places 32'h80000000 in its pc field.
- SKID, 1: 1 gives a two-entry skid buffer with registered s_ready. 0 gives a single register with combinational s_ready.
- BYPASS, 0: 1 makes the block combinational pass-through. All storage is removed.

Ports:
- clk  in  1  clock; the only clock.
- rst  in  1  reset; synchronous, active-high.
- flush  in  1  kill all held beats (branch mispredict or trap redirect).
- s_valid  in  1  upstream beat valid.
- s_ready  out  1  this stage can accept a beat.
- s_data  in  DATA_W  upstream payload.
- m_valid  out  1  downstream beat valid.
- m_ready  in  1  downstream accepts.
- m_data  out  DATA_W  downstream payload.
- occupancy  out  2  number of beats held: 0, 1 or 2.

Behaviour:
- Transfers: an input transfer occurs when s_valid & s_ready. An output transfer occurs when m_valid & m_ready. Both evaluate at posedge clk.
- Reset:
  - While rst is high: m_valid=0, s_ready=0, occupancy=0, skid slot empty, m_data=RESET_VAL.
  - s_ready becomes 1 in the first cycle after rst deasserts.
- State machine (SKID=1): states EMPTY, FULL, FULL_SKID. occupancy is 0, 1 or 2 respectively.
  - m_valid = (state != EMPTY).
  - s_ready = (state != FULL_SKID), and it is a registered signal.
  - EMPTY, input transfer: go to FULL. The main register loads s_data.
  - FULL, input and output transfer together: stay FULL. The main register loads s_data. This gives one beat per cycle.
  - FULL, output transfer only: go to EMPTY.
  - FULL, input transfer only: go to FULL_SKID. The skid register loads s_data.
  - FULL_SKID, output transfer: go to FULL. The main register loads the skid contents.
  - FULL_SKID: no input is accepted.
- SKID=0: single register.
  - s_ready = !rst & (!m_valid | m_ready). This path is combinational.
  - On input transfer: m_valid<=1 and m_data<=s_data.
  - Else if output transfer: m_valid<=0.
  - occupancy is 0 or 1.
- Ordering: beats leave in arrival order. No beat is duplicated or dropped except by flush.
- m_data hold: m_data is stable while m_valid & !m_ready. It changes only on the cycle after an output transfer or a load into an empty register.
- Flush: takes priority over every other event except rst.
  - Next cycle: state EMPTY, occupancy=0, m_valid=0. Data registers keep their old contents and are don't-care.
  - An input beat accepted in the flush cycle is discarded. Upstream is flushed in the same cycle.
  - An output transfer in the flush cycle counts as completed.
  - flush while rst is high: the rst result applies.
- Reset mid-operation: all held beats are discarded regardless of state.
- BYPASS=1:
  - m_valid = s_valid & !flush.
  - s_ready = m_ready.
  - m_data = s_data.
  - occupancy = 0.
  - rst and clk are unused.
- Upstream responsibility: no combinational path from s_valid to s_ready in any mode. s_data may change freely when !s_valid.

Decomposition:
- Shared package pipe_pkg:
  - Occupancy encodings OCC_EMPTY=0, OCC_ONE=1, OCC_TWO=2.
  - RESET_PC = 32'h80000000.
  - Per-stage payload widths and field offset constants (IDEX_W, EXMEM_W, ...).
- Optional sub-module pipe_slot: one DATA_W register with load enable and a valid bit. Instantiate it twice for main and skid.
- The state machine stays in pipe_stage_reg.

Test Plan:
- Reset then stream: rst 2 cycles, then s_valid=1 constant with m_ready=1 and data 1,2,3...8. Required: s_ready=1 on every cycle, m_data=1..8 on consecutive cycles, first beat out one cycle after acceptance, occupancy=1 steady.
- Backpressure with SKID=1: feed A,B,C with m_ready=0. Required: A and B accepted, occupancy=2, s_ready=0. C is held upstream. Raise m_ready. Required: A, B, C emerge in order with no gaps.
- Hold stability: m_valid=1 with m_data=32'hDEADBEEF, m_ready=0 for 5 cycles while s_data toggles. Required: m_data unchanged; s_data is captured only into the skid register.
- Flush in FULL_SKID: occupancy=2, assert flush for 1 cycle with s_valid=1. Required: next cycle m_valid=0, occupancy=0, s_ready=1, no beat ever emerges.
- SKID=0 instance: m_valid=1 and m_ready toggling 1,0,1. Required: s_ready follows m_ready combinationally and throughput is one beat per cycle when m_ready=1.
- Reset mid-stream: assert rst while occupancy=2. Required: next cycle m_valid=0, m_data=RESET_VAL (32'h80000000 in the pc field), s_ready=0 until rst is low.
